// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity encodings, default widths
// and frame-length constants also used by the matching receiver.
package uart_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int PRESC_W_DEF = 5;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int START_BITS        = 1;
  localparam int STOP_BITS         = 1;
  localparam int FRAME_BITS_NO_PAR = START_BITS + DATA_W_DEF + STOP_BITS;
  localparam int FRAME_BITS_PAR    = FRAME_BITS_NO_PAR + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Clocks occupied by one complete frame on the line.
  function automatic int frame_cycles(input logic par_en, input int prescale);
    return (par_en ? FRAME_BITS_PAR : FRAME_BITS_NO_PAR) * (prescale + 1);
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit prescale counter: counts 0..presc while enabled and pulses bit_done on the
// last clock of each bit, then restarts from zero.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               bit_done
);

  logic [PRESC_W-1:0] cnt;

  assign bit_done = en && (cnt == presc);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start / DATA_W data bits LSB first / optional parity / stop.
// Define UART_TX_BUF_EN to add a one-entry holding register for back-to-back frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  p_data,
  input  logic               data_valid,
  input  logic               par_en,
  input  logic               par_typ,
  input  logic [PRESC_W-1:0] prescale,
  output logic               tx_out,
  output logic               busy,
  output logic               ready
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  function automatic logic parity_of(input logic [DATA_W-1:0] d, input logic typ);
    return (typ == PAR_ODD) ? ~^d : ^d;
  endfunction

  tx_state_t          state;
  tx_state_t          state_nxt;
  logic [IDX_W-1:0]   bit_idx;
  logic [IDX_W-1:0]   idx_nxt;
  logic               tx_nxt;
  logic               bit_done;
  logic               accept;
  logic               frame_go;
  logic               hold_go;

  logic [DATA_W-1:0]  data_r;
  logic               par_en_r;
  logic [PRESC_W-1:0] presc_r;
  logic               par_bit_r;

  assign busy   = (state != IDLE);
  assign accept = data_valid && ready;

  uart_tx_bit_timer #(
    .PRESC_W (PRESC_W)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (busy),
    .presc    (presc_r),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      bit_idx <= '0;
      tx_out  <= 1'b1;
    end else begin
      state   <= state_nxt;
      bit_idx <= idx_nxt;
      tx_out  <= tx_nxt;
    end
  end

  // tx_out is registered from the next state so the line always matches the state register.
  always_comb begin
    state_nxt = state;
    idx_nxt   = bit_idx;
    frame_go  = 1'b0;
    tx_nxt    = 1'b1;

    case (state)
      IDLE: begin
        if (accept || hold_go) begin
          frame_go  = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = par_en_r ? PARITY : STOP;
          end else begin
            idx_nxt = bit_idx + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (hold_go) begin
            frame_go  = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = data_r[idx_nxt];
      PARITY:  tx_nxt = par_bit_r;
      default: tx_nxt = 1'b1;
    endcase
  end

`ifdef UART_TX_BUF_EN
  logic               hold_full;
  logic [DATA_W-1:0]  hold_data;
  logic               hold_par_en;
  logic               hold_par_typ;
  logic [PRESC_W-1:0] hold_presc;

  assign ready   = ~hold_full;
  assign hold_go = hold_full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_full <= 1'b0;
    end else if (frame_go && hold_full) begin
      hold_full <= 1'b0;
    end else if (accept && busy) begin
      hold_full <= 1'b1;
    end
  end

  // A byte accepted mid-frame is parked with its own line settings.
  always_ff @(posedge clk) begin
    if (accept && busy) begin
      hold_data    <= p_data;
      hold_par_en  <= par_en;
      hold_par_typ <= par_typ;
      hold_presc   <= prescale;
    end
  end

  always_ff @(posedge clk) begin
    if (frame_go) begin
      if (hold_full) begin
        data_r    <= hold_data;
        par_en_r  <= hold_par_en;
        presc_r   <= hold_presc;
        par_bit_r <= parity_of(hold_data, hold_par_typ);
      end else begin
        data_r    <= p_data;
        par_en_r  <= par_en;
        presc_r   <= prescale;
        par_bit_r <= parity_of(p_data, par_typ);
      end
    end
  end
`else
  assign ready   = ~busy;
  assign hold_go = 1'b0;

  always_ff @(posedge clk) begin
    if (frame_go) begin
      data_r    <= p_data;
      par_en_r  <= par_en;
      presc_r   <= prescale;
      par_bit_r <= parity_of(p_data, par_typ);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frames, hand-written corner sequences
// and randomized frames compared against a bit-list model of the serial line.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int LIMIT = 800;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic [4:0] prescale;
  logic       tx_out;
  logic       busy;
  logic       ready;

  uart_tx #(
    .DATA_W  (8),
    .PRESC_W (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy),
    .ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic [4:0] ps;
    logic       expar;
    int         exlen;
  } vec_t;

  vec_t tbl[6];
  int   checks   = 0;
  int   failures = 0;
  logic cap[$];
  logic expw[$];
  logic rdy2;
  logic rdy3;
  int   plist[6];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference line model: list of frame bits, each repeated prescale+1 times.
  task automatic model_frame(input logic [7:0] d, input logic pe, input logic pt, input int ps);
    logic bits[$];
    int   ones;
    ones = $countones(d);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pt ? ((ones % 2) == 0) : ((ones % 2) == 1));
    bits.push_back(1'b1);
    foreach (bits[j]) begin
      for (int r = 0; r <= ps; r++) expw.push_back(bits[j]);
    end
  endtask

  task automatic check_wave(input string name);
    int bad;
    bad = -1;
    chk({name, "_len"}, cap.size(), expw.size());
    for (int i = 0; i < cap.size() && i < expw.size(); i++) begin
      if (cap[i] !== expw[i] && bad < 0) bad = i;
    end
    chk({name, "_first_bad_idx"}, bad, -1);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt, input logic [4:0] ps,
                           input int chg_at, input int v2_at, input logic [7:0] v2d,
                           input int v3_at, input logic [7:0] v3d);
    int k;
    @(negedge clk);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    prescale   = ps;
    data_valid = 1'b1;
    chk("ready_before_send", ready, 1);
    @(negedge clk);
    data_valid = 1'b0;
    cap.delete();
    k = 0;
    while (busy === 1'b1 && k < LIMIT) begin
      cap.push_back(tx_out);
      data_valid = 1'b0;
      if (k == chg_at) begin
        prescale = 5'd31;
        par_en   = ~pe;
        par_typ  = ~pt;
        p_data   = ~d;
      end
      if (k == v2_at) begin
        p_data     = v2d;
        data_valid = 1'b1;
        rdy2       = ready;
      end
      if (k == v3_at) begin
        p_data     = v3d;
        data_valid = 1'b1;
        rdy3       = ready;
      end
      k++;
      @(negedge clk);
    end
    data_valid = 1'b0;
    chk("frame_timeout", int'(k >= LIMIT), 0);
    chk("idle_line_high", tx_out, 1);
  endtask

  initial begin
    logic [7:0] dec;
    int         ps;
    int         busy_seen;
    logic [7:0] rd;
    logic       rpe;
    logic       rpt;

    tbl[0] = '{d: 8'hA5, pe: 1'b0, pt: 1'b0, ps: 5'd7,  expar: 1'b0, exlen: 80};
    tbl[1] = '{d: 8'h07, pe: 1'b1, pt: 1'b0, ps: 5'd15, expar: 1'b1, exlen: 176};
    tbl[2] = '{d: 8'h07, pe: 1'b1, pt: 1'b1, ps: 5'd15, expar: 1'b0, exlen: 176};
    tbl[3] = '{d: 8'h00, pe: 1'b1, pt: 1'b0, ps: 5'd0,  expar: 1'b0, exlen: 11};
    tbl[4] = '{d: 8'hFF, pe: 1'b1, pt: 1'b1, ps: 5'd0,  expar: 1'b1, exlen: 11};
    tbl[5] = '{d: 8'h80, pe: 1'b0, pt: 1'b0, ps: 5'd31, expar: 1'b0, exlen: 320};
    plist  = '{0, 1, 2, 3, 7, 15};

    // Reset dominance with data_valid held high.
    rst        = 1'b0;
    data_valid = 1'b1;
    p_data     = 8'hFF;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prescale   = 5'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_tx_out", tx_out, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ready", ready, 1);
    end
    data_valid = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_busy", busy, 0);

    // Table-driven frames.
    for (int t = 0; t < 6; t++) begin
      ps = int'(tbl[t].ps);
      run_frame(tbl[t].d, tbl[t].pe, tbl[t].pt, tbl[t].ps, -1, -1, 8'h00, -1, 8'h00);
      expw.delete();
      model_frame(tbl[t].d, tbl[t].pe, tbl[t].pt, ps);
      check_wave("tbl");
      chk("tbl_len", cap.size(), tbl[t].exlen);
      if (cap.size() == tbl[t].exlen) begin
        for (int i = 0; i < 8; i++) dec[i] = cap[(1 + i) * (ps + 1) + ps / 2];
        chk("tbl_byte", dec, tbl[t].d);
        if (tbl[t].pe) chk("tbl_parity", cap[9 * (ps + 1) + ps / 2], tbl[t].expar);
      end
    end

    // Configuration changes mid-frame do not affect the frame in flight.
    run_frame(8'h5A, 1'b0, 1'b0, 5'd7, 20, -1, 8'h00, -1, 8'h00);
    expw.delete();
    model_frame(8'h5A, 1'b0, 1'b0, 7);
    check_wave("cfg_keep");
    run_frame(8'h5A, 1'b0, 1'b0, 5'd31, -1, -1, 8'h00, -1, 8'h00);
    expw.delete();
    model_frame(8'h5A, 1'b0, 1'b0, 31);
    check_wave("cfg_next");

    // Back-pressure: second byte mid-frame, third byte while the buffer is full.
    run_frame(8'h3C, 1'b0, 1'b0, 5'd7, -1, 10, 8'hC3, 20, 8'h99);
    expw.delete();
    model_frame(8'h3C, 1'b0, 1'b0, 7);
`ifdef UART_TX_BUF_EN
    model_frame(8'hC3, 1'b0, 1'b0, 7);
    chk("bp_ready_second", rdy2, 1);
`else
    chk("bp_ready_second", rdy2, 0);
`endif
    chk("bp_ready_third", rdy3, 0);
    check_wave("bp");
    busy_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
    end
    chk("bp_no_replay", busy_seen, 0);

    // Reset in the middle of a frame, with a byte pending in the buffer build.
    @(negedge clk);
    p_data     = 8'h55;
    par_en     = 1'b1;
    par_typ    = 1'b0;
    prescale   = 5'd3;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
    p_data     = 8'hAA;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy_before_rst", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx_out", tx_out, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ready, 1);
    rst       = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
    end
    chk("post_rst_quiet", busy_seen, 0);

    // Randomized frames against the line model.
    for (int n = 0; n < 40; n++) begin
      rd  = 8'($urandom);
      rpe = 1'($urandom_range(0, 1));
      rpt = 1'($urandom_range(0, 1));
      ps  = plist[$urandom_range(0, 5)];
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(rd, rpe, rpt, 5'(ps), -1, -1, 8'h00, -1, 8'h00);
      expw.delete();
      model_frame(rd, rpe, rpt, ps);
      check_wave("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
